// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop, LSB first.
// Result, carry-out and signed overflow are registered together on the last bit.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | one operand bit processed per clock
// DONE   | one-cycle completion pulse; start here chains the next operation
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_s;
  logic             r_co;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cnext;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_ins;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_sum      = r_a[0] ^ r_b[0] ^ r_c;
    w_cnext    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_ins      = '0;
    w_ins[WIDTH-1] = w_sum;
    w_acc_next = (r_acc >> 1) | w_ins;
    w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_last     = (r_cnt == LAST);
  end

  // Subtract is folded in at accept: B is stored inverted and the carry flop
  // holds ~ci, so RUN always performs a plain addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnext;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_s     <= w_acc_next;
            r_co    <= w_cnext;
            r_ovf   <= r_c ^ w_cnext;
            r_state <= S_DONE;
          end
        end
        default: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{mode}};
            r_c     <= ci ^ mode;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign s    = r_s;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed vectors, random ops against an arithmetic
// model, handshake/reset corner cases, and an exhaustive WIDTH=3 sweep.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, mode8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ovf8;
  logic [7:0] s8;
  logic       start3 = 1'b0, mode3 = 1'b0, ci3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, co3, ovf3;
  logic [2:0] s3;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .s(s8), .co(co8), .ovf(ovf8));

  serial_addsub #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .a(a3), .b(b3), .ci(ci3),
    .busy(busy3), .done(done3), .s(s3), .co(co3), .ovf(ovf3));

  typedef struct {
    bit       m;
    bit [7:0] a;
    bit [7:0] b;
    bit       ci;
    bit [7:0] s;
    bit       co;
    bit       ovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic for the unsigned result and signed range test.
  function automatic void model(input int w, input bit m, input int a, input int b,
                                input bit ci, output int s, output bit co, output bit ovf);
    int mask, tot, sa, sb, res;
    mask = (1 << w) - 1;
    tot  = m ? (a + ((~b) & mask) + (ci ? 0 : 1)) : (a + b + ci);
    s    = tot & mask;
    co   = ((tot >> w) & 1) != 0;
    sa   = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb   = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    res  = m ? (sa - sb - ci) : (sa + sb + ci);
    ovf  = (res > (1 << (w - 1)) - 1) || (res < -(1 << (w - 1)));
  endfunction

  task automatic op8(input bit m, input bit [7:0] a_i, input bit [7:0] b_i, input bit ci_i,
                     output int busy_cyc);
    bit to;
    @(negedge clk);
    start8 = 1'b1; mode8 = m; a8 = a_i; b8 = b_i; ci8 = ci_i;
    @(negedge clk);
    start8 = 1'b0;
    busy_cyc = 0;
    to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin to = 1'b0; break; end
      if (busy8) busy_cyc++;
      @(negedge clk);
    end
    chk("op8_timeout", int'(to), 0);
  endtask

  task automatic op3(input bit m, input bit [2:0] a_i, input bit [2:0] b_i, input bit ci_i);
    bit to;
    @(negedge clk);
    start3 = 1'b1; mode3 = m; a3 = a_i; b3 = b_i; ci3 = ci_i;
    @(negedge clk);
    start3 = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done3) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk("op3_timeout", int'(to), 0);
  endtask

  initial begin
    vec_t vecs[6];
    int   bc, es, gap;
    bit   eco, eovf, to;
    bit [7:0] ra, rb;
    bit   rm, rci;

    vecs[0] = '{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_s",    int'(s8),    0);
    chk("rst_co",   int'(co8),   0);
    chk("rst_ovf",  int'(ovf8),  0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].ci, bc);
      chk("vec_s",    int'(s8),   int'(vecs[i].s));
      chk("vec_co",   int'(co8),  int'(vecs[i].co));
      chk("vec_ovf",  int'(ovf8), int'(vecs[i].ovf));
      chk("vec_busy_cycles", bc, 8);
      @(negedge clk);
      chk("done_one_cycle", int'(done8), 0);
    end

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255)); rb = 8'($urandom_range(0, 255));
      op8(rm, ra, rb, rci, bc);
      model(8, rm, int'(ra), int'(rb), rci, es, eco, eovf);
      chk("rnd_s",   int'(s8),   es);
      chk("rnd_co",  int'(co8),  int'(eco));
      chk("rnd_ovf", int'(ovf8), int'(eovf));
    end

    // start pulsed and operands changed mid-RUN must not disturb the operation
    op8(1'b0, 8'h22, 8'h11, 1'b0, bc);
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b1; ci8 = 1'b1;
      @(negedge clk);
      chk("run_s_stable", int'(s8), 8'h33);
    end
    start8 = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk("ign_timeout", int'(to), 0);
    chk("ign_s",  int'(s8),  8'h10);
    chk("ign_co", int'(co8), 0);

    // start held through DONE: back-to-back operations 9 cycles apart
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h03; b8 = 8'h04; ci8 = 1'b0;
    @(negedge clk);
    mode8 = 1'b1; a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin to = 1'b0; break; end
      @(negedge clk);
    end
    chk("b2b_first_timeout", int'(to), 0);
    chk("b2b_first_s", int'(s8), 8'h07);
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_after_done", int'(busy8), 1);
    gap = 1;
    to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin to = 1'b0; break; end
      gap++;
      @(negedge clk);
    end
    chk("b2b_second_timeout", int'(to), 0);
    chk("b2b_gap", gap, 9);
    chk("b2b_second_s",  int'(s8),  8'h0F);
    chk("b2b_second_co", int'(co8), 1);

    // asynchronous reset in the middle of a run
    op8(1'b0, 8'h7F, 8'h01, 1'b0, bc);
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy8), 0);
    chk("mid_rst_done", int'(done8), 0);
    chk("mid_rst_s",    int'(s8),    0);
    chk("mid_rst_co",   int'(co8),   0);
    chk("mid_rst_ovf",  int'(ovf8),  0);
    repeat (12) begin
      @(negedge clk);
      if (done8) chk("mid_rst_no_done", int'(done8), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done8 || busy8) chk("post_rst_idle", int'(done8 | busy8), 0);
    end
    op8(1'b0, 8'h01, 8'h01, 1'b0, bc);
    chk("post_rst_s",  int'(s8),  8'h02);
    chk("post_rst_co", int'(co8), 0);

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          for (int c = 0; c < 2; c++) begin
            op3(m[0], a[2:0], b[2:0], c[0]);
            model(3, m[0], a, b, c[0], es, eco, eovf);
            chk("w3_s",   int'(s3),   es);
            chk("w3_co",  int'(co3),  int'(eco));
            chk("w3_ovf", int'(ovf3), int'(eovf));
          end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. One full-adder slice plus a carry flip-flop processes one operand bit per clock, LSB first.
- A start/done handshake controls each operation; result, carry and signed overflow are registered at completion.
- It is the sequential, width-generalised successor to the single-bit full adder. It adds a subtract mode and overflow detection.
- Intended as a low-area arithmetic unit for datapaths that can tolerate a WIDTH+1 cycle latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32. Internal bit-counter width = clog2(WIDTH)+1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  1  operation select: 0 = add, 1 = subtract; latched on accept.
- a  input  WIDTH  operand A; latched on accept.
- b  input  WIDTH  operand B; latched on accept.
- ci  input  1  carry-in (add) / borrow-in (subtract); latched on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- s  output  WIDTH  result; holds the last completed value.
- co  output  1  carry out of the MSB (subtract: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0; internal shift registers, carry FF and counter cleared.
- Reset asserted mid-operation aborts immediately. No done pulse; outputs return to 0.
- FSM states: IDLE, RUN, DONE.
- Accept: start=1 at a rising edge while in IDLE or DONE.
  - On accept, latch a, b and mode.
  - Latch carry FF = ci (add) or ~ci (subtract).
  - Counter = 0; next state = RUN.
- start is ignored while in RUN. Latched operands are unaffected by input changes after accept.
- RUN: each edge processes bit i = counter.
  - Operand bit b' = b[i] XOR mode.
  - sum_i = a[i]^b'^c; c_next = majority(a[i], b', c).
  - sum_i is shifted into an internal result register, LSB first.
  - The carry into bit WIDTH-1 is recorded on the edge processing the MSB.
- On the edge processing bit WIDTH-1, next state = DONE and the outputs update together:
  - s = assembled result.
  - co = final carry.
  - ovf = (carry into MSB) XOR (carry out of MSB).
- The subtract result is a - b - ci = a + ~b + ~ci, modulo 2^WIDTH.
- Latency: accept at edge E0; bits processed on edges E1..E_WIDTH.
  - done=1 and new s/co/ovf are visible after E_WIDTH, for exactly one cycle.
  - busy=1 from after E0 until after E_WIDTH.
- DONE lasts one cycle, then:
  - with start=1: accept and go to RUN (back-to-back, throughput one operation per WIDTH+1 cycles);
  - otherwise: go to IDLE.
- s, co and ovf change only at completion. They are stable during RUN and IDLE.
- WIDTH=1: RUN lasts one edge; ovf = ci_internal XOR co.

Test Plan:
- WIDTH=8, add.
  - a=8'h0F, b=8'h01, ci=0 -> after 8 RUN edges: done pulse, s=8'h10, co=0, ovf=0; busy high for exactly 8 cycles.
  - a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ovf=1.
  - a=8'hFF, b=8'h01, ci=1 -> s=8'h01, co=1, ovf=0.
- Subtract.
  - a=8'h05, b=8'h07, ci=0 -> s=8'hFE, co=0 (borrow), ovf=0.
  - a=8'h80, b=8'h01, ci=0 -> s=8'h7F, co=1, ovf=1.
  - a=8'h10, b=8'h01, ci=1 -> s=8'h0E, co=1.
- Handshake.
  - Pulse start again and change a/b during RUN -> ignored; result matches the first operands.
  - start held high across DONE -> second operation accepted; done pulses are 9 cycles apart.
- Reset mid-operation: assert rst_n=0 at RUN bit 4, asynchronously between edges -> busy, done, s, co and ovf go to 0 immediately; no done pulse.
  - After release, a fresh add 8'h01+8'h01 gives s=8'h02.
- Exhaustive cross-check at WIDTH=3: all 2×8×8×2 combinations of mode, a, b and ci.
  - s/co must match {co,s} = a+b+ci (add) or a+~b+~ci (subtract).
  - ovf must match the sign rule.
